// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write-port scheduler.
package rf_pkg;

  localparam int RF_AW = 5;
  localparam int RF_DW = 8;

  // Bit positions in the internal grant vector.
  localparam int REQ_CPU = 0;
  localparam int REQ_DBG = 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_write_sched_if.sv
// Requester and RAM-lane signals of the write-port scheduler.
interface rf_write_sched_if
  import rf_pkg::*;
#(
  parameter int AW = RF_AW,
  parameter int DW = RF_DW
);

  logic          clr_req;
  logic          req0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] data0;
  logic          gnt0;
  logic          req1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] data1;
  logic          gnt1;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_di;
  logic          ram_we;
  logic          busy;

  modport slave (
    input  clr_req, req0, addr0, data0, req1, addr1, data1,
    output gnt0, gnt1, ram_addr, ram_di, ram_we, busy
  );

  modport master (
    output clr_req, req0, addr0, data0, req1, addr1, data1,
    input  gnt0, gnt1, ram_addr, ram_di, ram_we, busy
  );

endinterface

// File: rtl/rf_starve_cnt.sv
// Saturating count of consecutive cycles in which requester 1 was denied.
module rf_starve_cnt #(
  parameter int unsigned LIMIT = 4,
  parameter int          CW    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIM)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == LIM);

endmodule

// File: rtl/rf_write_sched.sv
// Write-port arbiter and power-on clear sequencer for the LUT-RAM register file.
//   state    | meaning
//   ST_CLEAR | writing CLR_VAL to every entry, requesters held off
//   ST_RUN   | arbitrating req0/req1 onto the write port
module rf_write_sched
  import rf_pkg::*;
#(
  parameter int          AW      = RF_AW,
  parameter int          DW      = RF_DW,
  parameter int unsigned STARVE  = 4,
  parameter logic [DW-1:0] CLR_VAL = '0
) (
  input logic             clk,
  input logic             rst_n,
  rf_write_sched_if.slave bus
);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic [AW-1:0] last_addr_q, last_addr_d;
  logic [DW-1:0] last_di_q, last_di_d;

  logic [1:0]    gnt;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] di;
  logic          starve_inc, starve_clr, starve_at_limit;

  always_comb begin
    gnt  = '0;
    we   = 1'b0;
    addr = last_addr_q;
    di   = last_di_q;
    if (state_q == ST_CLEAR) begin
      we   = 1'b1;
      addr = clr_cnt_q;
      di   = CLR_VAL;
    end else begin
      // req0 wins unless req1 has been denied STARVE cycles in a row.
      gnt[REQ_DBG] = bus.req1 && (starve_at_limit || !bus.req0);
      gnt[REQ_CPU] = bus.req0 && !gnt[REQ_DBG];
      if (gnt[REQ_DBG]) begin
        we   = 1'b1;
        addr = bus.addr1;
        di   = bus.data1;
      end else if (gnt[REQ_CPU]) begin
        we   = 1'b1;
        addr = bus.addr0;
        di   = bus.data0;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    last_addr_d = last_addr_q;
    last_di_d   = last_di_q;
    if (we) begin
      last_addr_d = addr;
      last_di_d   = di;
    end
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (&clr_cnt_q) begin
        state_d = ST_RUN;
      end
    end else if (bus.clr_req) begin
      state_d   = ST_CLEAR;
      clr_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      last_addr_q <= '0;
      last_di_q   <= CLR_VAL;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      last_addr_q <= last_addr_d;
      last_di_q   <= last_di_d;
    end
  end

  assign starve_inc = (state_q == ST_RUN) && bus.req1 && !gnt[REQ_DBG];
  assign starve_clr = (state_q == ST_CLEAR) || bus.clr_req || gnt[REQ_DBG] || !bus.req1;

  rf_starve_cnt #(.LIMIT(STARVE)) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .at_limit (starve_at_limit)
  );

  // Reset gates the strobes directly so the lanes never see a write while rst_n is low.
  assign bus.ram_we   = we & rst_n;
  assign bus.gnt0     = gnt[REQ_CPU] & rst_n;
  assign bus.gnt1     = gnt[REQ_DBG] & rst_n;
  assign bus.busy     = (state_q == ST_CLEAR) | ~rst_n;
  assign bus.ram_addr = addr;
  assign bus.ram_di   = di;

endmodule

// File: tb/tb_rf_write_sched.sv
// Randomized bench for rf_write_sched against a cycle-level behavioural model and a LUT-RAM model.
module tb_rf_write_sched;
  import rf_pkg::*;

  localparam int AW = RF_AW;
  localparam int DW = RF_DW;
  localparam int DEPTH = 1 << AW;
  localparam int STARVE = 4;
  localparam logic [DW-1:0] CLR_VAL = 8'h00;

  typedef struct packed {
    logic          g0;
    logic          g1;
    logic          we;
    logic          busy;
    logic [AW-1:0] addr;
    logic [DW-1:0] di;
  } outs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  rf_write_sched_if #(.AW(AW), .DW(DW)) bus ();

  rf_write_sched #(.AW(AW), .DW(DW), .STARVE(STARVE), .CLR_VAL(CLR_VAL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // The RAM lanes: sync write on port D, async read on port A.
  logic [DW-1:0] lane_ram [DEPTH];
  always @(posedge clk) if (bus.ram_we === 1'b1) lane_ram[bus.ram_addr] <= bus.ram_di;

  // Behavioural model state.
  bit            m_clearing;
  int            m_idx;
  int            m_starve;
  logic [AW-1:0] m_last_addr;
  logic [DW-1:0] m_last_di;
  logic [DW-1:0] m_mem [DEPTH];

  function automatic outs_t observe();
    outs_t o;
    o.g0 = bus.gnt0; o.g1 = bus.gnt1; o.we = bus.ram_we; o.busy = bus.busy;
    o.addr = bus.ram_addr; o.di = bus.ram_di;
    return o;
  endfunction

  function automatic outs_t predict();
    outs_t e;
    e.g0 = 1'b0; e.g1 = 1'b0; e.we = 1'b0; e.busy = m_clearing;
    e.addr = m_last_addr; e.di = m_last_di;
    if (!rst_n) begin
      e.busy = 1'b1; e.addr = '0; e.di = CLR_VAL;
    end else if (m_clearing) begin
      e.we = 1'b1; e.addr = AW'(m_idx); e.di = CLR_VAL;
    end else if (bus.req1 && (m_starve == STARVE || !bus.req0)) begin
      e.g1 = 1'b1; e.we = 1'b1; e.addr = bus.addr1; e.di = bus.data1;
    end else if (bus.req0) begin
      e.g0 = 1'b1; e.we = 1'b1; e.addr = bus.addr0; e.di = bus.data0;
    end
    return e;
  endfunction

  task automatic reset_model();
    m_clearing = 1'b1; m_idx = 0; m_starve = 0;
    m_last_addr = '0; m_last_di = CLR_VAL;
  endtask

  task automatic set_idle();
    bus.clr_req = 1'b0;
    bus.req0 = 1'b0; bus.addr0 = '0; bus.data0 = '0;
    bus.req1 = 1'b0; bus.addr1 = '0; bus.data1 = '0;
  endtask

  task automatic sample(output outs_t o, output outs_t e);
    @(negedge clk);
    o = observe();
    e = predict();
  endtask

  // Step the model across one rising edge using the inputs held during the cycle.
  task automatic advance();
    outs_t e;
    @(posedge clk);
    if (rst_n) begin
      e = predict();
      if (e.we) begin
        m_mem[e.addr] = e.di; m_last_addr = e.addr; m_last_di = e.di;
      end
      if (m_clearing) begin
        m_idx++;
        if (m_idx == DEPTH) begin m_clearing = 1'b0; m_idx = 0; end
      end else begin
        if (bus.req1 && !e.g1) m_starve = (m_starve < STARVE) ? m_starve + 1 : STARVE;
        else m_starve = 0;
        if (bus.clr_req) begin m_clearing = 1'b1; m_idx = 0; m_starve = 0; end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    reset_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    outs_t o, want;
    set_idle();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    rst_n = 1'b0;
    reset_model();
    #3;
    o = observe();
    want = '{g0: 1'b0, g1: 1'b0, we: 1'b0, busy: 1'b1, addr: '0, di: CLR_VAL};
    total++;
    if (o !== want) begin bad++; $display("FAIL reset_outputs got=%h want=%h", o, want); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_idle();
  endtask

  task automatic test_clear_seq();
    outs_t o, e;
    int nwe = 0;
    for (int k = 0; k < DEPTH; k++) begin
      sample(o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL clear_step k=%0d got=%h want=%h", k, o, e); end
      if (o.we && o.busy && o.addr == AW'(k) && o.di == CLR_VAL) nwe++;
      advance();
    end
    total++;
    if (nwe != DEPTH) begin bad++; $display("FAIL clear_count got=%0d want=%0d", nwe, DEPTH); end
    sample(o, e);
    total++;
    if ({o.busy, o.we} !== 2'b00 || o !== e) begin
      bad++; $display("FAIL clear_done got=%h want=%h", o, e);
    end
    advance();
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (lane_ram[i] !== CLR_VAL) begin
        bad++; $display("FAIL clear_mem a=%0d got=%h want=%h", i, lane_ram[i], CLR_VAL);
      end
    end
  endtask

  task automatic test_req_during_clear();
    outs_t o, e;
    int cyc = 0;
    int first = -1;
    set_idle();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      sample(o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL rdc_idle got=%h want=%h", o, e); end
      advance();
      cyc++;
    end
    bus.req0 = 1'b1; bus.addr0 = 5'd5; bus.data0 = 8'hA5;
    while (first < 0 && cyc < 60) begin
      sample(o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL rdc_cycle c=%0d got=%h want=%h", cyc, o, e); end
      if (o.g0 === 1'b1) begin
        first = cyc;
        total++;
        if ({o.we, o.busy, o.addr, o.di} !== {1'b1, 1'b0, 5'd5, 8'hA5}) begin
          bad++; $display("FAIL rdc_grant got=%h want=we1 busy0 addr05 diA5", o);
        end
      end
      advance();
      cyc++;
    end
    total++;
    if (first != DEPTH) begin bad++; $display("FAIL rdc_first_grant got=%0d want=%0d", first, DEPTH); end
    set_idle();
  endtask

  task automatic test_contention();
    outs_t o, e;
    logic exp_g1;
    set_idle();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      bus.addr0 = AW'($urandom_range(0, DEPTH - 1)); bus.data0 = DW'($urandom);
      bus.addr1 = AW'($urandom_range(0, DEPTH - 1)); bus.data1 = DW'($urandom);
      sample(o, e);
      exp_g1 = ((k % (STARVE + 1)) == STARVE);
      total++;
      if (o !== e || o.g1 !== exp_g1 || o.g0 !== !exp_g1) begin
        bad++; $display("FAIL contention k=%0d got=%h want=%h g1=%0b", k, o, e, exp_g1);
      end
      advance();
    end
    set_idle();
  endtask

  task automatic test_back_to_back();
    outs_t o, e;
    set_idle();
    bus.req0 = 1'b1; bus.addr0 = 5'd9; bus.data0 = 8'h11;
    sample(o, e);
    total++;
    if (o !== e || {o.g0, o.we, o.addr, o.di} !== {1'b1, 1'b1, 5'd9, 8'h11}) begin
      bad++; $display("FAIL b2b_first got=%h want=%h", o, e);
    end
    advance();
    bus.data0 = 8'h22;
    sample(o, e);
    total++;
    if (o !== e || {o.g0, o.we, o.addr, o.di} !== {1'b1, 1'b1, 5'd9, 8'h22}) begin
      bad++; $display("FAIL b2b_second got=%h want=%h", o, e);
    end
    advance();
    set_idle();
    total++;
    if (lane_ram[9] !== 8'h22) begin bad++; $display("FAIL b2b_read got=%h want=22", lane_ram[9]); end
  endtask

  task automatic test_clr_coincident();
    outs_t o, e;
    int nwe = 0;
    set_idle();
    bus.req1 = 1'b1; bus.addr1 = 5'd31; bus.data1 = 8'h3C; bus.clr_req = 1'b1;
    sample(o, e);
    total++;
    if (o !== e || {o.g1, o.g0, o.we, o.addr, o.di} !== {1'b1, 1'b0, 1'b1, 5'd31, 8'h3C}) begin
      bad++; $display("FAIL clrc_grant got=%h want=%h", o, e);
    end
    advance();
    set_idle();
    total++;
    if (lane_ram[31] !== 8'h3C) begin bad++; $display("FAIL clrc_commit got=%h want=3c", lane_ram[31]); end
    for (int k = 0; k < DEPTH; k++) begin
      sample(o, e);
      total++;
      if (o !== e || o.addr !== AW'(k) || o.busy !== 1'b1) begin
        bad++; $display("FAIL clrc_clear k=%0d got=%h want=%h", k, o, e);
      end
      if (o.we) nwe++;
      advance();
    end
    total++;
    if (nwe != DEPTH || lane_ram[31] !== CLR_VAL) begin
      bad++; $display("FAIL clrc_final writes=%0d mem31=%h want=%0d/%h", nwe, lane_ram[31], DEPTH, CLR_VAL);
    end
  endtask

  task automatic test_reset_mid_clear();
    outs_t o, e, want;
    int nwe = 0;
    set_idle();
    bus.clr_req = 1'b1;
    advance();
    set_idle();
    for (int k = 0; k < 17; k++) begin
      sample(o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL rmc_pre k=%0d got=%h want=%h", k, o, e); end
      advance();
    end
    bus.req0 = 1'b1; bus.addr0 = AW'($urandom_range(0, DEPTH - 1)); bus.data0 = 8'h5A;
    #2;
    rst_n = 1'b0;
    reset_model();
    #1;
    o = observe();
    want = '{g0: 1'b0, g1: 1'b0, we: 1'b0, busy: 1'b1, addr: '0, di: CLR_VAL};
    total++;
    if (o !== want) begin bad++; $display("FAIL rmc_in_reset got=%h want=%h", o, want); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_idle();
    for (int k = 0; k < DEPTH; k++) begin
      sample(o, e);
      total++;
      if (o !== e || o.addr !== AW'(k) || o.we !== 1'b1) begin
        bad++; $display("FAIL rmc_restart k=%0d got=%h want=%h", k, o, e);
      end
      if (o.we) nwe++;
      advance();
    end
    sample(o, e);
    total++;
    if (nwe != DEPTH || o.busy !== 1'b0 || o !== e) begin
      bad++; $display("FAIL rmc_done writes=%0d got=%h want=%h", nwe, o, e);
    end
    advance();
  endtask

  task automatic test_random();
    outs_t o, e;
    int guard = 0;
    for (int k = 0; k < 400; k++) begin
      bus.req0 = 1'($urandom_range(0, 1)); bus.addr0 = AW'($urandom_range(0, DEPTH - 1));
      bus.data0 = DW'($urandom);
      bus.req1 = 1'($urandom_range(0, 1)); bus.addr1 = AW'($urandom_range(0, DEPTH - 1));
      bus.data1 = DW'($urandom);
      bus.clr_req = ($urandom_range(0, 39) == 0);
      sample(o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL random k=%0d got=%h want=%h", k, o, e); end
      advance();
    end
    set_idle();
    while (m_clearing && guard < 2 * DEPTH) begin
      sample(o, e);
      total++;
      if (o !== e) begin bad++; $display("FAIL random_drain got=%h want=%h", o, e); end
      advance();
      guard++;
    end
    total++;
    if (m_clearing) begin bad++; $display("FAIL random_drain_timeout got=busy want=idle"); end
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (lane_ram[i] !== m_mem[i]) begin
        bad++; $display("FAIL random_mem a=%0d got=%h want=%h", i, lane_ram[i], m_mem[i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    test_reset();
    test_clear_seq();
    test_req_during_clear();
    test_contention();
    test_back_to_back();
    test_clr_coincident();
    test_reset_mid_clear();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
